// File: rtl/ahb_posted_wbuf_if.sv
// rtl/ahb_posted_wbuf_if.sv - AHB-lite bus bundle shared by the upstream and downstream ports
interface ahb_posted_wbuf_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic [DW-1:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRDATA
    );
endinterface

// File: rtl/ahb_posted_wbuf.sv
// rtl/ahb_posted_wbuf.sv - posted write buffer with strongly ordered reads and fence handshake
module ahb_posted_wbuf #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_posted_wbuf_if.slave    s_bus,
    ahb_posted_wbuf_if.master   m_bus,
    input  logic                fence_req,
    output logic                fence_ack,
    output logic [CW-1:0]       wb_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_RADDR,
        ST_RDATA
    } state_t;

    state_t         state_q, state_d;

    // upstream data-phase context captured at the address phase
    logic           dp_valid_q, dp_valid_d;
    logic           dp_write_q, dp_write_d;
    logic [AW-1:0]  dp_addr_q, dp_addr_d;
    logic [2:0]     dp_size_q, dp_size_d;

    // write FIFO
    logic [AW-1:0]  mem_addr_q [DEPTH];
    logic [2:0]     mem_size_q [DEPTH];
    logic [DW-1:0]  mem_data_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // registered downstream controls and upstream read data
    logic [AW-1:0]  m_haddr_q, m_haddr_d;
    logic [1:0]     m_htrans_q, m_htrans_d;
    logic           m_hwrite_q, m_hwrite_d;
    logic [2:0]     m_hsize_q, m_hsize_d;
    logic [DW-1:0]  m_hwdata_q, m_hwdata_d;
    logic [DW-1:0]  hrdata_q, hrdata_d;

    logic           full;
    logic           pop;
    logic           push;
    logic           rd_done;
    logic           rd_pending;
    logic           s_hready;
    logic [AW-1:0]  head_addr;
    logic [2:0]     head_size;
    logic           unused_htrans0;

    assign unused_htrans0 = s_bus.HTRANS[0];

    // upstream handshake: stall a write only when full with no pop, stall a read until it returns
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop        = (state_q == ST_WDATA) && m_bus.HREADY;
        rd_done    = (state_q == ST_RDATA) && m_bus.HREADY;
        rd_pending = dp_valid_q && !dp_write_q;
        s_hready   = 1'b1;
        if (dp_valid_q) begin
            if (dp_write_q) begin
                s_hready = !full || pop;
            end else begin
                s_hready = rd_done;
            end
        end
        push = dp_valid_q && dp_write_q && s_hready;
        // an empty FIFO being pushed this cycle is bypassed so the drain starts one cycle later
        if (count_q == '0) begin
            head_addr = dp_addr_q;
            head_size = dp_size_q;
        end else begin
            head_addr = mem_addr_q[rd_ptr_q];
            head_size = mem_size_q[rd_ptr_q];
        end
    end

    // next-state for the upstream capture, FIFO pointers and drain FSM
    always_comb begin
        state_d    = state_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_size_d  = dp_size_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        m_haddr_d  = m_haddr_q;
        m_htrans_d = m_htrans_q;
        m_hwrite_d = m_hwrite_q;
        m_hsize_d  = m_hsize_q;
        m_hwdata_d = m_hwdata_q;
        hrdata_d   = hrdata_q;

        if (s_hready) begin
            dp_valid_d = s_bus.HTRANS[1];
            if (s_bus.HTRANS[1]) begin
                dp_write_d = s_bus.HWRITE;
                dp_addr_d  = s_bus.HADDR;
                dp_size_d  = s_bus.HSIZE;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (rd_done) begin
            hrdata_d = m_bus.HRDATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 || push) begin
                    state_d    = ST_WADDR;
                    m_htrans_d = HTRANS_NONSEQ;
                    m_hwrite_d = 1'b1;
                    m_haddr_d  = head_addr;
                    m_hsize_d  = head_size;
                end else if (rd_pending) begin
                    state_d    = ST_RADDR;
                    m_htrans_d = HTRANS_NONSEQ;
                    m_hwrite_d = 1'b0;
                    m_haddr_d  = dp_addr_q;
                    m_hsize_d  = dp_size_q;
                end
            end
            ST_WADDR: begin
                if (m_bus.HREADY) begin
                    state_d    = ST_WDATA;
                    m_htrans_d = HTRANS_IDLE;
                    m_hwdata_d = mem_data_q[rd_ptr_q];
                end
            end
            ST_WDATA: begin
                if (m_bus.HREADY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (m_bus.HREADY) begin
                    state_d    = ST_RDATA;
                    m_htrans_d = HTRANS_IDLE;
                end
            end
            ST_RDATA: begin
                if (m_bus.HREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers; reset drops buffered writes and any in-flight downstream transfer
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_size_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_haddr_q  <= '0;
            m_htrans_q <= HTRANS_IDLE;
            m_hwrite_q <= 1'b0;
            m_hsize_q  <= '0;
            m_hwdata_q <= '0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_size_q  <= dp_size_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m_haddr_q  <= m_haddr_d;
            m_htrans_q <= m_htrans_d;
            m_hwrite_q <= m_hwrite_d;
            m_hsize_q  <= m_hsize_d;
            m_hwdata_q <= m_hwdata_d;
            hrdata_q   <= hrdata_d;
            if (push) begin
                mem_addr_q[wr_ptr_q] <= dp_addr_q;
                mem_size_q[wr_ptr_q] <= dp_size_q;
                mem_data_q[wr_ptr_q] <= s_bus.HWDATA;
            end
        end
    end

    assign s_bus.HREADY  = s_hready;
    assign s_bus.HRDATA  = rd_done ? m_bus.HRDATA : hrdata_q;
    assign m_bus.HADDR   = m_haddr_q;
    assign m_bus.HTRANS  = m_htrans_q;
    assign m_bus.HWRITE  = m_hwrite_q;
    assign m_bus.HSIZE   = m_hsize_q;
    assign m_bus.HWDATA  = m_hwdata_q;
    assign fence_ack     = fence_req && (count_q == '0) && (state_q == ST_IDLE);
    assign wb_count      = count_q;

endmodule

// File: tb/tb_ahb_posted_wbuf.sv
// tb/tb_ahb_posted_wbuf.sv - directed scoreboard bench for ahb_posted_wbuf
module tb_ahb_posted_wbuf;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int CW = 3;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          fence_req;
    logic          fence_ack;
    logic [CW-1:0] wb_count;

    ahb_posted_wbuf_if #(.AW(AW), .DW(DW)) s_if ();
    ahb_posted_wbuf_if #(.AW(AW), .DW(DW)) m_if ();

    ahb_posted_wbuf #(.AW(AW), .DW(DW), .DEPTH(4), .CW(CW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .s_bus     (s_if),
        .m_bus     (m_if),
        .fence_req (fence_req),
        .fence_ack (fence_ack),
        .wb_count  (wb_count)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t          wq[$];
    logic [31:0]  rq[$];
    logic [63:0]  fab_mem [logic [31:0]];

    int           ws          = 0;
    int           hold_cycles = 0;
    int           wait_left   = 0;
    bit           new_phase   = 1'b1;
    bit           mon_pend    = 1'b0;
    bit           mon_write   = 1'b0;
    logic [31:0]  mon_addr    = '0;
    bit           prev_stall  = 1'b0;
    logic [31:0]  prev_haddr;
    logic [1:0]   prev_htrans;
    logic [63:0]  prev_hwdata;
    int           wr_seen     = 0;
    int           peak        = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // fabric model: inserts ws wait states per phase, or holds HREADY low for hold_cycles
    always @(posedge HCLK) begin
        #2;
        if (!HRESETn) begin
            wait_left   = 0;
            m_if.HREADY = 1'b1;
            m_if.HRDATA = '0;
        end else begin
            if (new_phase) begin
                wait_left = (m_if.HTRANS == 2'b10 || mon_pend) ? ws : 0;
                new_phase = 1'b0;
            end
            if (hold_cycles > 0) begin
                hold_cycles--;
                m_if.HREADY = 1'b0;
            end else if (wait_left > 0) begin
                wait_left--;
                m_if.HREADY = 1'b0;
            end else begin
                m_if.HREADY = 1'b1;
            end
            m_if.HRDATA = (mon_pend && !mon_write && fab_mem.exists(mon_addr)) ? fab_mem[mon_addr] : 64'h0;
        end
    end

    // downstream monitor: ordering, stability under wait states, scoreboard pops
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            mon_pend   = 1'b0;
            prev_stall = 1'b0;
            new_phase  = 1'b1;
        end else begin
            if (int'(wb_count) > peak) peak = int'(wb_count);
            if (prev_stall) begin
                chk("m_haddr_stable", m_if.HADDR, prev_haddr);
                chk("m_htrans_stable", m_if.HTRANS, prev_htrans);
                chk("m_hwdata_stable", m_if.HWDATA, prev_hwdata);
            end
            if (mon_pend && m_if.HREADY) begin
                if (mon_write) begin
                    chk("write_expected", wq.size() > 0, 1'b1);
                    if (wq.size() > 0) begin
                        wr_t e;
                        e = wq.pop_front();
                        chk("w_addr", mon_addr, e.addr);
                        chk("w_data", m_if.HWDATA, e.data);
                    end
                    fab_mem[mon_addr] = m_if.HWDATA;
                    wr_seen++;
                end
                mon_pend = 1'b0;
            end
            if (m_if.HTRANS == 2'b10 && m_if.HREADY) begin
                mon_pend  = 1'b1;
                mon_write = m_if.HWRITE;
                mon_addr  = m_if.HADDR;
                if (!m_if.HWRITE) begin
                    chk("read_after_writes", wq.size(), 0);
                    chk("read_expected", rq.size() > 0, 1'b1);
                    if (rq.size() > 0) chk("r_addr", m_if.HADDR, rq.pop_front());
                end
            end
            new_phase   = m_if.HREADY;
            prev_stall  = !m_if.HREADY && (m_if.HTRANS == 2'b10 || mon_pend);
            prev_haddr  = m_if.HADDR;
            prev_htrans = m_if.HTRANS;
            prev_hwdata = m_if.HWDATA;
        end
    end

    // one upstream cycle: optional address phase and/or write data, waits out HREADY
    task automatic beat(input bit a_en, input bit a_wr, input logic [31:0] a,
                        input bit d_en, input logic [63:0] d,
                        output int st, output logic [63:0] rd);
        s_if.HTRANS = a_en ? 2'b10 : 2'b00;
        s_if.HADDR  = a_en ? a : 32'h0;
        s_if.HWRITE = a_wr;
        s_if.HSIZE  = 3'd3;
        if (d_en) s_if.HWDATA = d;
        st = 0;
        @(negedge HCLK);
        while (s_if.HREADY !== 1'b1 && st < 64) begin
            @(negedge HCLK);
            st++;
        end
        if (st >= 64) chk("s_hready_timeout", s_if.HREADY, 1'b1);
        rd = s_if.HRDATA;
        @(posedge HCLK);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((wq.size() != 0 || wb_count != 0 || mon_pend) && c < 400) begin
            @(posedge HCLK);
            #1;
            c++;
        end
        chk("drain_wq_empty", wq.size(), 0);
        chk("drain_count", wb_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          base;
        int          c;
        logic [63:0] rd;

        HRESETn     = 1'b0;
        fence_req   = 1'b0;
        s_if.HTRANS = 2'b00;
        s_if.HADDR  = '0;
        s_if.HWRITE = 1'b0;
        s_if.HSIZE  = 3'd0;
        s_if.HWDATA = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_s_hready", s_if.HREADY, 1'b1);
        chk("rst_m_htrans", m_if.HTRANS, 2'b00);
        chk("rst_m_haddr", m_if.HADDR, 32'h0);
        chk("rst_s_hrdata", s_if.HRDATA, 64'h0);
        chk("rst_wb_count", wb_count, 0);
        chk("rst_fence_ack", fence_ack, 1'b0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cycles(1);

        // pipelined burst of 4 writes with a zero-wait fabric
        peak = 0;
        base = wr_seen;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wq.push_back('{addr: 32'h2000_0000 + 32'(8 * (i - 1)), data: 64'h11 * i});
            beat(i < 4, 1'b1, 32'h2000_0000 + 32'(8 * i), i > 0, 64'h11 * i, st, rd);
            if (i > 0) chk("burst_zero_wait", st, 0);
        end
        wait_drain();
        chk("burst_peak_3_or_4", (peak >= 3 && peak <= 4), 1'b1);
        chk("burst_writes", wr_seen - base, 4);

        // fill the FIFO against a stalled fabric; the fifth data phase must wait for a pop
        peak = 0;
        base = wr_seen;
        hold_cycles = 12;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) wq.push_back('{addr: 32'h2000_0100 + 32'(8 * (i - 1)), data: 64'h1000 + 64'(i)});
            beat(i < 5, 1'b1, 32'h2000_0100 + 32'(8 * i), i > 0, 64'h1000 + 64'(i), st, rd);
            if (i > 0 && i < 5) chk("full_zero_wait", st, 0);
            if (i == 5) chk("full_fifth_stalls", st > 0, 1'b1);
        end
        wait_drain();
        chk("full_peak", peak, 4);
        chk("full_writes", wr_seen - base, 5);

        // read after write, read address phase overlapping the write data phase
        rq.push_back(32'h2000_0040);
        beat(1'b1, 1'b1, 32'h2000_0040, 1'b0, 64'h0, st, rd);
        wq.push_back('{addr: 32'h2000_0040, data: 64'hDEAD_BEEF});
        beat(1'b1, 1'b0, 32'h2000_0040, 1'b1, 64'hDEAD_BEEF, st, rd);
        chk("raw_write_zero_wait", st, 0);
        beat(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, st, rd);
        chk("raw_rdata", rd, 64'hDEAD_BEEF);
        chk("raw_read_waits", st >= 2, 1'b1);
        cycles(3);
        chk("rdata_hold", s_if.HRDATA, 64'hDEAD_BEEF);

        // three downstream wait states in every phase
        ws = 3;
        rq.push_back(32'h2000_0048);
        beat(1'b1, 1'b1, 32'h2000_0048, 1'b0, 64'h0, st, rd);
        wq.push_back('{addr: 32'h2000_0048, data: 64'hCAFE_0000_1234_5678});
        beat(1'b1, 1'b0, 32'h2000_0048, 1'b1, 64'hCAFE_0000_1234_5678, st, rd);
        chk("ws_write_zero_wait", st, 0);
        beat(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, st, rd);
        chk("ws_rdata", rd, 64'hCAFE_0000_1234_5678);
        chk("ws_read_stalls", st >= 8, 1'b1);
        wait_drain();
        ws = 0;

        // fence: ack only once both buffered writes have popped
        fence_req = 1'b1;
        cycles(1);
        @(negedge HCLK);
        chk("fence_ack_empty", fence_ack, 1'b1);
        @(posedge HCLK);
        #1;
        hold_cycles = 6;
        base = wr_seen;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wq.push_back('{addr: 32'h2000_0080 + 32'(8 * (i - 1)), data: 64'hF0 + 64'(i)});
            beat(i < 2, 1'b1, 32'h2000_0080 + 32'(8 * i), i > 0, 64'hF0 + 64'(i), st, rd);
        end
        @(negedge HCLK);
        chk("fence_ack_busy", fence_ack, 1'b0);
        c = 0;
        while (fence_ack !== 1'b1 && c < 100) begin
            @(negedge HCLK);
            c++;
        end
        chk("fence_ack_rise", fence_ack, 1'b1);
        chk("fence_after_pops", wr_seen - base, 2);
        chk("fence_count", wb_count, 0);
        @(posedge HCLK);
        #1;
        beat(1'b1, 1'b1, 32'h2000_0090, 1'b0, 64'h0, st, rd);
        wq.push_back('{addr: 32'h2000_0090, data: 64'h77});
        beat(1'b0, 1'b0, 32'h0, 1'b1, 64'h77, st, rd);
        @(negedge HCLK);
        chk("fence_ack_drop", fence_ack, 1'b0);
        @(posedge HCLK);
        #1;
        wait_drain();
        fence_req = 1'b0;

        // reset while the first of two buffered writes sits in its data phase
        ws = 3;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wq.push_back('{addr: 32'h2000_00C0 + 32'(8 * (i - 1)), data: 64'hAB + 64'(i)});
            beat(i < 2, 1'b1, 32'h2000_00C0 + 32'(8 * i), i > 0, 64'hAB + 64'(i), st, rd);
        end
        c = 0;
        while (!(mon_pend && mon_write) && c < 100) begin
            @(negedge HCLK);
            c++;
        end
        chk("reached_wdata", (mon_pend && mon_write), 1'b1);
        @(posedge HCLK);
        #1;
        chk("pre_reset_count", wb_count, 2);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        chk("mid_reset_count", wb_count, 0);
        chk("mid_reset_htrans", m_if.HTRANS, 2'b00);
        wq.delete();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        ws = 0;
        cycles(1);

        // recovery after reset: write then read back
        rq.push_back(32'h2000_0200);
        beat(1'b1, 1'b1, 32'h2000_0200, 1'b0, 64'h0, st, rd);
        wq.push_back('{addr: 32'h2000_0200, data: 64'h5555_AAAA_0000_0001});
        beat(1'b1, 1'b0, 32'h2000_0200, 1'b1, 64'h5555_AAAA_0000_0001, st, rd);
        beat(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, st, rd);
        chk("post_reset_rdata", rd, 64'h5555_AAAA_0000_0001);
        wait_drain();

        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_posted_wbuf.md
Name: ahb_posted_wbuf

Overview:
- Posted-write buffer between the core's AHB-lite master port and the 64-bit system AHB-lite fabric (AHBlite_sys_0 master interface).
- Absorbs CPU stores into a FIFO with zero wait states and drains them to the fabric in order.
- Reads are strongly ordered: a read completes only after every earlier write has completed downstream.
- A fence handshake lets software or debug logic wait for the buffer to drain.

Parameters:
AW, 32, address width
DW, 64, data width
DEPTH, 4, write FIFO entries (power of two, >=2)
CW, 3, width of wb_count (log2(DEPTH)+1)

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
S_HADDR  in  AW  upstream address
S_HTRANS  in  2  upstream transfer type
S_HWRITE  in  1  upstream write
S_HSIZE  in  3  upstream size
S_HWDATA  in  DW  upstream write data
S_HREADY  out  1  upstream ready (also the upstream bus HREADY)
S_HRDATA  out  DW  upstream read data
M_HADDR  out  AW  downstream address
M_HTRANS  out  2  downstream transfer type (IDLE=00 or NONSEQ=10 only)
M_HWRITE  out  1  downstream write
M_HSIZE  out  3  downstream size
M_HWDATA  out  DW  downstream write data
M_HREADY  in  1  downstream ready from fabric
M_HRDATA  in  DW  downstream read data
fence_req  in  1  level request to drain the buffer
fence_ack  out  1  high while FIFO empty, FSM in IDLE and fence_req high
wb_count  out  CW  occupied FIFO entries

Behaviour:
- Reset: synchronous, sampled on HCLK rising edge while HRESETn=0. Values: S_HREADY=1, S_HRDATA=0, M_HTRANS=00, M_HADDR=0, M_HWRITE=0, M_HSIZE=0, M_HWDATA=0, wb_count=0, fence_ack=0, FSM=IDLE.
- Reset mid-operation discards buffered writes and any in-flight downstream transfer.
- Upstream address phase is accepted when S_HTRANS[1] & S_HREADY. The block registers HADDR, HSIZE and HWRITE.
- Upstream write data phase: push {addr, size, S_HWDATA} into the FIFO in the cycle S_HREADY=1.
  - S_HREADY=0 while the FIFO is full and no pop occurs in that cycle.
  - Push and pop in the same cycle are allowed, including when full. wb_count is then unchanged.
- Upstream read data phase: S_HREADY=0 until the read returns.
  - The read is issued downstream only when the FIFO is empty and the FSM is in IDLE.
  - S_HRDATA=M_HRDATA and S_HREADY=1 in the RDATA cycle where M_HREADY=1. S_HRDATA holds its last value otherwise.
- Drain FSM states: IDLE, WADDR, WDATA, RADDR, RDATA.
  - IDLE -> WADDR if FIFO not empty (writes take priority over a pending read).
  - IDLE -> RADDR if FIFO empty and a read is pending.
  - WADDR: drive M_HTRANS=10, M_HWRITE=1, address and size from the FIFO head. Hold until M_HREADY=1, then go to WDATA.
  - WDATA: M_HTRANS=00, M_HWDATA=head data. On M_HREADY=1, pop and return to IDLE.
  - RADDR: M_HTRANS=10, M_HWRITE=0, held until M_HREADY=1, then go to RDATA.
  - RDATA: on M_HREADY=1, complete the upstream read and return to IDLE.
- Downstream transfers are non-pipelined: at least 2 cycles each. Address and control are held stable while M_HREADY=0.
- Write latency seen by the CPU is 0 wait states when not full.
- Read latency with an empty buffer is at least 2 wait states: capture cycle, RADDR, RDATA.
- A read issued while n writes are buffered waits for all n writes to complete first.
- Simultaneous events:
  - A write data-phase push in the same cycle as a read address phase: the write enters the FIFO before the read is considered.
  - A push into an empty FIFO while in IDLE: the drain starts the next cycle.
- fence_req does not block new writes. fence_ack deasserts the cycle after a new write is pushed.
- Sizes 0..3 pass through unchanged. The block performs no lane shifting.

Test Plan:
- Reset then idle: HRESETn=0 for 2 cycles -> S_HREADY=1, M_HTRANS=00, wb_count=0, fence_ack=0.
- Burst of 4 writes with M_HREADY=1 to 0x2000_0000..0x2000_0018 (data 0x11..0x44):
  - all accepted with 0 wait states; wb_count peaks at 3 or 4;
  - the fabric sees 4 NONSEQ writes in order with matching HWDATA.
- Full FIFO: hold M_HREADY=0 and issue 5 writes -> the 5th data phase sees S_HREADY=0 until the first pop, then completes; no write is lost or reordered.
- Read after write: write 0xDEAD_BEEF to 0x2000_0040, then read 0x2000_0040 -> downstream write completes before RADDR is issued; S_HRDATA=M_HRDATA.
- Downstream wait states: M_HREADY=0 for 3 cycles in WADDR and in RDATA -> M_HADDR, M_HTRANS and M_HWDATA stay stable; upstream stalls correspondingly.
- Fence and reset: 2 writes buffered with fence_req=1 -> fence_ack rises only after the second pop. Asserting HRESETn=0 during WDATA -> wb_count=0 and M_HTRANS=00 next cycle.
